mux_n_pipe: RTL and testbench
=============================

// Module: mux_n_pipe
// PURPOSE
//   Parametrised N-way, WIDTH-bit datapath select stage with one registered output slot and valid/ready handshake.
//   Generalises the 3-way combinational operand select: any N, any WIDTH, configurable default for out-of-range
//   select, error reporting, and a pipeline register so the select can sit on a stage boundary (EX operand/forwarding).
// PARAMETERS
//   WIDTH        32   data width per source, >=1
//   N            3    number of sources, 2..16
//   SEL_W        2    select width, 2**SEL_W >= N
//   DEFAULT_VAL  0    WIDTH-bit value output when sel >= N
// PORTS
//   clk          in   1          rising-edge clock
//   rst          in   1          synchronous reset, active-high
//   flush        in   1          synchronous discard of held beat
//   in_valid     in   1          upstream beat present
//   in_ready     out  1          stage can accept this cycle
//   src_flat     in   N*WIDTH    source k at bits [k*WIDTH +: WIDTH]
//   sel          in   SEL_W      source index, sampled with beat
//   out_valid    out  1          held beat valid
//   out_ready    in   1          downstream accepts held beat
//   sel_result   out  WIDTH      registered selected data
//   sel_invalid  out  1          held beat had sel >= N
//   err_count    out  8          saturating count of accepted sel >= N beats
// BEHAVIOUR
//   Reset: out_valid=0, sel_result=0, sel_invalid=0, err_count=0; any held beat dropped, rst overrides all inputs.
//   States: EMPTY (out_valid=0), FULL (out_valid=1). in_ready = !out_valid || out_ready (combinational).
//   Accept = in_valid && in_ready; Release = out_valid && out_ready.
//   EMPTY: Accept -> FULL; else stay.
//   FULL: Release && !Accept -> EMPTY; Release && Accept -> FULL with new beat (back-to-back, 1 beat/cycle);
//     !out_ready -> hold; sel_result/sel_invalid stable while out_valid && !out_ready.
//   Latency: beat accepted at edge t is visible on sel_result/out_valid after edge t (1 cycle).
//   Selection: sel < N -> source[sel], sel_invalid=0; sel >= N -> DEFAULT_VAL, sel_invalid=1.
//   sel_result/sel_invalid load only on Accept; otherwise hold (no zeroing on release).
//   err_count: +1 on each Accept with sel >= N; saturates at 255; cleared only by rst (not by flush).
//   flush (rst=0): next state EMPTY; in_ready forced 0 that cycle (no accept); sel_result value retained.
//   flush && out_ready same cycle: beat counts as released downstream (out_valid was 1); stage still ends EMPTY.
//   in_valid with in_ready=0: no state change; upstream must hold src_flat/sel stable until accepted.
//   Source vector and sel not registered before accept; no combinational path sel/src -> outputs.
// TESTING
//   1 rst 2 cycles, then N=3: src0=0x11,src1=0x22,src2=0x33, sel=1, in_valid=1, out_ready=1 -> next cycle out_valid=1, sel_result=0x22.
//   2 sel=3 (N=3) accepted -> sel_result=DEFAULT_VAL(0), sel_invalid=1, err_count 0->1; 300 such beats -> err_count=255.
//   3 out_ready=0 with beat A held, present B -> in_ready=0, sel_result=A for 5 cycles; raise out_ready -> A released, B loaded next edge.
//   4 continuous in_valid/out_ready=1, sel cycling 0,1,2 for 10 cycles -> 10 beats out, 1/cycle, order preserved, in_ready never 0.
//   5 flush while FULL, in_valid=1 -> in_ready=0, out_valid=0 next cycle, err_count unchanged.
//   6 rst asserted while FULL and out_ready=0 -> next cycle all outputs at reset values, in_ready=1.
//   7 N=16, SEL_W=4, WIDTH=8: sweep sel 0..15 -> sel_result = src_flat[sel*8 +: 8], sel_invalid never 1.

Source files
------------

// File: rtl/mux_n_pipe.sv
// N-way WIDTH-bit select stage with a single registered output slot.
// Valid/ready handshake; out-of-range selects give DEFAULT_VAL and are counted.
module mux_n_pipe #(
    parameter int unsigned            WIDTH       = 32,
    parameter int unsigned            N           = 3,
    parameter int unsigned            SEL_W       = 2,
    parameter logic [WIDTH-1:0]       DEFAULT_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WIDTH-1:0]   src_flat,
    input  logic [SEL_W-1:0]     sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     sel_result,
    output logic                 sel_invalid,
    output logic [7:0]           err_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             accept;
    logic             rel;
    logic             in_range;
    logic [WIDTH-1:0] pick;

    assign out_valid = (state_q == FULL);
    assign in_ready  = !flush && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign rel       = out_valid && out_ready;
    assign in_range  = (int'(sel) < int'(N));

    always_comb begin
        pick = DEFAULT_VAL;
        for (int k = 0; k < int'(N); k++) begin
            if (sel == SEL_W'(k)) begin
                pick = src_flat[k*WIDTH +: WIDTH];
            end
        end
    end

    // flush wins over any accept/release; a released beat still leaves us empty
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) state_d = FULL;
                FULL:  if (rel && !accept) state_d = EMPTY;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_result  <= '0;
            sel_invalid <= 1'b0;
            err_count   <= 8'd0;
        end else if (accept) begin
            sel_result  <= pick;
            sel_invalid <= !in_range;
            if (!in_range && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed testbench for mux_n_pipe: default 3x32 instance plus a 16x8 instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_mux_n_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] src_flat;
    logic [1:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sel_result;
    logic        sel_invalid;
    logic [7:0]  err_count;

    logic         w_flush;
    logic         w_in_valid;
    logic         w_in_ready;
    logic [127:0] w_src_flat;
    logic [3:0]   w_sel;
    logic         w_out_valid;
    logic         w_out_ready;
    logic [7:0]   w_sel_result;
    logic         w_sel_invalid;
    logic [7:0]   w_err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_n_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src_flat    (src_flat),
        .sel         (sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sel_result  (sel_result),
        .sel_invalid (sel_invalid),
        .err_count   (err_count)
    );

    mux_n_pipe #(.WIDTH(8), .N(16), .SEL_W(4), .DEFAULT_VAL(8'h00)) dut_w (
        .clk         (clk),
        .rst         (rst),
        .flush       (w_flush),
        .in_valid    (w_in_valid),
        .in_ready    (w_in_ready),
        .src_flat    (w_src_flat),
        .sel         (w_sel),
        .out_valid   (w_out_valid),
        .out_ready   (w_out_ready),
        .sel_result  (w_sel_result),
        .sel_invalid (w_sel_invalid),
        .err_count   (w_err_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        flush = 0; in_valid = 0; out_ready = 1;
        src_flat = '0; sel = 0;
        w_flush = 0; w_in_valid = 0; w_out_ready = 1;
        w_src_flat = '0; w_sel = 0;
        do_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (sel_result !== 32'h0) begin
            errors++; $display("FAIL reset_sel_result got %h want 0", sel_result);
        end
        checks++;
        if (sel_invalid !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_err got inv=%b cnt=%0d want 0/0", sel_invalid, err_count);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_select();
        src_flat = {32'h33, 32'h22, 32'h11};
        out_ready = 1; in_valid = 1; sel = 1;
        step();
        checks++;
        if (out_valid !== 1'b1 || sel_result !== 32'h22 || sel_invalid !== 1'b0) begin
            errors++;
            $display("FAIL select_1 got v=%b r=%h i=%b want 1/22/0", out_valid, sel_result, sel_invalid);
        end
        sel = 0;
        step();
        checks++;
        if (sel_result !== 32'h11) begin
            errors++; $display("FAIL select_0 got %h want 11", sel_result);
        end
        sel = 2;
        step();
        checks++;
        if (sel_result !== 32'h33) begin
            errors++; $display("FAIL select_2 got %h want 33", sel_result);
        end
        in_valid = 0;
        step();
        checks++;
        if (out_valid !== 1'b0 || sel_result !== 32'h33) begin
            errors++;
            $display("FAIL release_hold got v=%b r=%h want 0/33", out_valid, sel_result);
        end
    endtask

    task automatic test_invalid_sel();
        in_valid = 1; out_ready = 1; sel = 3;
        step();
        checks++;
        if (sel_result !== 32'h0 || sel_invalid !== 1'b1 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL invalid_first got r=%h i=%b c=%0d want 0/1/1", sel_result, sel_invalid, err_count);
        end
        for (int i = 1; i < 300; i++) step();
        checks++;
        if (err_count !== 8'd255) begin
            errors++; $display("FAIL err_saturate got %0d want 255", err_count);
        end
        in_valid = 0;
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        src_flat = {32'hB2, 32'h22, 32'hA1};
        in_valid = 1; out_ready = 1; sel = 0;
        step();
        out_ready = 0; sel = 2;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_in_ready got %b want 0", in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || sel_result !== 32'hA1) begin
                errors++;
                $display("FAIL bp_hold_%0d got v=%b r=%h want 1/a1", i, out_valid, sel_result);
            end
        end
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready got %b want 1", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || sel_result !== 32'hB2) begin
            errors++;
            $display("FAIL bp_load_b got v=%b r=%h want 1/b2", out_valid, sel_result);
        end
        in_valid = 0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drain got %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        int beats = 0;
        src_flat = {32'h30, 32'h20, 32'h10};
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            sel = 2'(i % 3);
            exp = 32'((i % 3 + 1) * 16);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready_%0d got %b want 1", i, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || sel_result !== exp) begin
                errors++;
                $display("FAIL b2b_beat_%0d got v=%b r=%h want 1/%h", i, out_valid, sel_result, exp);
            end else begin
                beats++;
            end
        end
        checks++;
        if (beats !== 10) begin
            errors++; $display("FAIL b2b_count got %0d want 10", beats);
        end
        in_valid = 0;
        step();
    endtask

    task automatic test_flush();
        src_flat = {32'h30, 32'h20, 32'h10};
        in_valid = 1; out_ready = 1; sel = 1;
        step();
        out_ready = 0; flush = 1; sel = 3;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_in_ready got %b want 0", in_ready);
        end
        step();
        flush = 0; in_valid = 0;
        checks++;
        if (out_valid !== 1'b0 || err_count !== 8'd0 || sel_result !== 32'h20) begin
            errors++;
            $display("FAIL flush_state got v=%b c=%0d r=%h want 0/0/20", out_valid, err_count, sel_result);
        end
        out_ready = 1;
    endtask

    task automatic test_reset_full();
        in_valid = 1; out_ready = 1; sel = 3;
        step();
        out_ready = 0; rst = 1; sel = 2;
        step();
        rst = 0; in_valid = 0;
        checks++;
        if (out_valid !== 1'b0 || sel_result !== 32'h0 || sel_invalid !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_full got v=%b r=%h i=%b c=%0d want 0/0/0/0",
                     out_valid, sel_result, sel_invalid, err_count);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_full_ready got %b want 1", in_ready);
        end
        out_ready = 1;
    endtask

    task automatic test_wide();
        logic [7:0] exp;
        for (int k = 0; k < 16; k++) w_src_flat[k*8 +: 8] = 8'(k * 7 + 3);
        w_in_valid = 1; w_out_ready = 1;
        for (int s = 0; s < 16; s++) begin
            w_sel = 4'(s);
            exp = 8'(s * 7 + 3);
            step();
            checks++;
            if (w_out_valid !== 1'b1 || w_sel_result !== exp || w_sel_invalid !== 1'b0) begin
                errors++;
                $display("FAIL wide_sel_%0d got v=%b r=%h i=%b want 1/%h/0",
                         s, w_out_valid, w_sel_result, w_sel_invalid, exp);
            end
        end
        w_in_valid = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_select();
        test_invalid_sel();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_full();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
